ysyx_23060240_branch_resolve: RTL and testbench
===============================================

// Module: ysyx_23060240_branch_resolve
// PURPOSE
//  Parametrised EX-stage branch resolution unit. Evaluates RV conditional branches at XLEN width
//  and computes the taken target. Checks the result against the IF-stage prediction and trains an
//  internal bimodal BHT of 2-bit saturating counters. Sits between ID/EX and the PC/redirect logic.
//  Uses valid/ready handshakes and a one-entry registered output stage.
// PARAMETERS
//  XLEN       32     operand/PC width (32 or 64)
//  BHT_DEPTH  16     BHT entries; power of two, >=2; IDX=$clog2(BHT_DEPTH)
//  CNT_INIT   2'b01  counter value after reset (weakly not-taken)
// PORTS
//  clk             in   1     clock, rising edge
//  rst_n           in   1     asynchronous reset, active low
//  flush           in   1     pipeline flush; kills held result and blocks acceptance this cycle
//  in_valid        in   1     branch op valid
//  in_ready        out  1     unit can accept op
//  in_pc           in   XLEN  PC of branch
//  in_rs1,in_rs2   in   XLEN  source operands
//  in_imm          in   XLEN  sign-extended B-type offset
//  in_branch_type  in   3     001 beq,010 bne,011 blt,100 bge,101 bltu,110 bgeu, else not-branch
//  in_pred_taken   in   1     prediction that fetch used for this op
//  lookup_pc       in   XLEN  IF-stage PC for prediction
//  lookup_taken    out  1     counter[lookup_pc index][1] (combinational read)
//  out_valid       out  1     result valid
//  out_ready       in   1     consumer accepts result
//  out_taken       out  1     resolved direction
//  out_target      out  XLEN  in_pc+in_imm
//  out_mispredict  out  1     out_taken != in_pred_taken
//  out_redirect_pc out  XLEN  taken ? target : pc+4
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0; out_taken/out_mispredict=0; out_target/out_redirect_pc=0;
//    every BHT counter=CNT_INIT. Reset mid-operation discards the held result.
//  - in_ready = !flush && (!out_valid || out_ready). fire = in_valid && in_ready.
//  - Latency 1: on fire, results register on the same edge; out_valid=1 next cycle.
//  - Hold: out_valid && !out_ready -> all out_* stable, in_ready=0.
//  - Back-to-back: out_valid && out_ready && in_valid -> new result replaces old, one op/cycle.
//  - Drain: out_ready && !fire -> out_valid clears on that edge.
//  - flush=1 -> out_valid cleared on next edge, no fire, no BHT update; flush dominates all.
//  - Compare: beq/bne equality; blt/bge signed (bge is >=); bltu/bgeu unsigned; all at full XLEN.
//  - Arithmetic mod 2^XLEN: target=pc+imm, fallthrough=pc+4; wrap-around silently allowed.
//  - Not-branch types (000,111): out_taken=0, redirect=pc+4, mispredict=in_pred_taken, no BHT update.
//  - BHT index = pc[IDX+1:2], for both lookup and update.
//  - BHT update on fire of a real branch: taken -> cnt+1 saturating at 11;
//    not-taken -> cnt-1 saturating at 00.
//  - Same-cycle lookup and update of one index: lookup_taken returns the pre-update value.
// TESTING
//  - Reset then lookup any pc -> lookup_taken=0; out_valid=0; in_ready=1.
//  - bge rs1=5 rs2=5, pc=0x100, imm=0x20, pred=0 -> next cycle out_taken=1,
//    target=redirect=0x120, mispredict=1.
//  - blt rs1=0xFFFFFFFF rs2=1 -> taken; bltu with same operands -> not taken,
//    redirect=pc+4; XLEN=64 variant too.
//  - 3 taken beq at pc=0x40 -> counter 01->10->11->11; lookup_taken(0x40)=1;
//    pc=0x80 (alias at DEPTH=16) also reads 1.
//  - out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable;
//    release -> one result/cycle, none lost or duplicated.
//  - flush during hold and during fire -> out_valid=0 next cycle, BHT unchanged;
//    pc=0xFFFFFFFC imm=8 -> target 0x4.

Source files
------------

// File: rtl/ysyx_23060240_branch_resolve.sv
// EX-stage branch resolution: compare, target, mispredict, bimodal BHT.
// One-entry registered output stage behind a valid/ready handshake.
module ysyx_23060240_branch_resolve #(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 16,
  parameter logic [1:0] CNT_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [2:0]      in_branch_type,
  input  logic            in_pred_taken,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic            out_mispredict,
  output logic [XLEN-1:0] out_redirect_pc
);

  localparam int IDX = $clog2(BHT_DEPTH);

  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BGE  = 3'b100;
  localparam logic [2:0] BR_BLTU = 3'b101;
  localparam logic [2:0] BR_BGEU = 3'b110;

  logic [1:0]      bht [BHT_DEPTH];
  logic [IDX-1:0]  lk_idx;
  logic [IDX-1:0]  up_idx;
  logic [1:0]      cnt_cur;
  logic [1:0]      cnt_nxt;
  logic            fire;
  logic            is_br;
  logic            taken;
  logic            eq;
  logic            lt;
  logic            ltu;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fall;
  logic [XLEN-1:0] redirect;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign fire     = in_valid && in_ready;

  assign eq  = (in_rs1 == in_rs2);
  assign lt  = ($signed(in_rs1) < $signed(in_rs2));
  assign ltu = (in_rs1 < in_rs2);

  assign target   = in_pc + in_imm;
  assign fall     = in_pc + XLEN'(4);
  assign redirect = taken ? target : fall;

  // Lookup reads the stored counter, so a same-cycle update is not visible.
  assign lk_idx       = lookup_pc[IDX+1:2];
  assign lookup_taken = bht[lk_idx][1];

  assign up_idx  = in_pc[IDX+1:2];
  assign cnt_cur = bht[up_idx];

  // Direction decode; unknown types resolve as not-taken non-branches.
  always_comb begin
    is_br = 1'b1;
    taken = 1'b0;
    unique case (1'b1)
      (in_branch_type == BR_BEQ):  taken = eq;
      (in_branch_type == BR_BNE):  taken = !eq;
      (in_branch_type == BR_BLT):  taken = lt;
      (in_branch_type == BR_BGE):  taken = !lt;
      (in_branch_type == BR_BLTU): taken = ltu;
      (in_branch_type == BR_BGEU): taken = !ltu;
      default:                     is_br = 1'b0;
    endcase
  end

  // Saturating 2-bit counter step toward the resolved direction.
  always_comb begin
    cnt_nxt = cnt_cur;
    if (taken) begin
      if (cnt_cur != 2'b11) cnt_nxt = cnt_cur + 2'b01;
    end else begin
      if (cnt_cur != 2'b00) cnt_nxt = cnt_cur - 2'b01;
    end
  end

  // BHT training on every accepted real branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CNT_INIT;
    end else if (fire && is_br) begin
      bht[up_idx] <= cnt_nxt;
    end
  end

  // Output stage: flush kills, fire loads, consumer drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_taken       <= 1'b0;
      out_target      <= '0;
      out_mispredict  <= 1'b0;
      out_redirect_pc <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid       <= 1'b1;
      out_taken       <= taken;
      out_target      <= target;
      out_mispredict  <= (taken != in_pred_taken);
      out_redirect_pc <= redirect;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_23060240_branch_resolve.sv
// Bench for ysyx_23060240_branch_resolve: directed vectors,
// BHT training, hold/backpressure, flush, reset and XLEN=64.
module tb_ysyx_23060240_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic [2:0]  in_branch_type = '0;
  logic        in_pred_taken = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        lookup_taken;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_taken;
  logic [31:0] out_target;
  logic        out_mispredict;
  logic [31:0] out_redirect_pc;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [63:0] w_pc = '0;
  logic [63:0] w_rs1 = '0;
  logic [63:0] w_rs2 = '0;
  logic [63:0] w_imm = '0;
  logic [2:0]  w_type = '0;
  logic        w_pred = 1'b0;
  logic        w_lookup_taken;
  logic        w_out_valid;
  logic        w_out_taken;
  logic [63:0] w_out_target;
  logic        w_out_mis;
  logic [63:0] w_out_redir;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  ysyx_23060240_branch_resolve u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_branch_type(in_branch_type),
    .in_pred_taken(in_pred_taken),
    .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_target(out_target),
    .out_mispredict(out_mispredict),
    .out_redirect_pc(out_redirect_pc)
  );

  ysyx_23060240_branch_resolve #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_pc(w_pc), .in_rs1(w_rs1), .in_rs2(w_rs2),
    .in_imm(w_imm), .in_branch_type(w_type),
    .in_pred_taken(w_pred),
    .lookup_pc(64'h0), .lookup_taken(w_lookup_taken),
    .out_valid(w_out_valid), .out_ready(1'b1),
    .out_taken(w_out_taken), .out_target(w_out_target),
    .out_mispredict(w_out_mis),
    .out_redirect_pc(w_out_redir)
  );

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        pred;
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] redir;
    logic        mis;
  } vec_t;

  vec_t tv [14];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    ntot++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      npass++;
  endtask

  task automatic drive(input logic [2:0] t, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic pred);
    in_branch_type = t;
    in_pc          = pc;
    in_rs1         = a;
    in_rs2         = b;
    in_imm         = imm;
    in_pred_taken  = pred;
  endtask

  task automatic fire_one;
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic issue64(input string name, input logic [2:0] t,
                         input logic [63:0] pc, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] imm,
                         input logic exp_t, input logic [63:0] exp_tgt,
                         input logic [63:0] exp_rd);
    @(negedge clk);
    w_type = t; w_pc = pc; w_rs1 = a; w_rs2 = b; w_imm = imm;
    w_pred = 1'b0;
    w_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w_in_valid = 1'b0;
    chk({name, ".valid"}, 64'(w_out_valid), 64'd1);
    chk({name, ".taken"}, 64'(w_out_taken), 64'(exp_t));
    chk({name, ".target"}, w_out_target, exp_tgt);
    chk({name, ".redir"}, w_out_redir, exp_rd);
    chk({name, ".mis"}, 64'(w_out_mis), 64'(exp_t));
  endtask

  logic dirs [9];
  logic exps [9];

  initial begin
    tv[0]  = '{3'b100, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0,
               1'b1, 32'h120, 32'h120, 1'b1};
    tv[1]  = '{3'b011, 32'h200, 32'hFFFFFFFF, 32'd1, 32'h10, 1'b1,
               1'b1, 32'h210, 32'h210, 1'b0};
    tv[2]  = '{3'b101, 32'h200, 32'hFFFFFFFF, 32'd1, 32'h10, 1'b1,
               1'b0, 32'h210, 32'h204, 1'b1};
    tv[3]  = '{3'b110, 32'h300, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, 1'b0,
               1'b1, 32'h2F0, 32'h2F0, 1'b1};
    tv[4]  = '{3'b100, 32'h300, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, 1'b0,
               1'b0, 32'h2F0, 32'h304, 1'b0};
    tv[5]  = '{3'b001, 32'h400, 32'd7, 32'd8, 32'h40, 1'b0,
               1'b0, 32'h440, 32'h404, 1'b0};
    tv[6]  = '{3'b010, 32'h400, 32'd7, 32'd8, 32'h40, 1'b0,
               1'b1, 32'h440, 32'h440, 1'b1};
    tv[7]  = '{3'b001, 32'hFFFFFFFC, 32'd3, 32'd3, 32'h8, 1'b1,
               1'b1, 32'h4, 32'h4, 1'b0};
    tv[8]  = '{3'b010, 32'hFFFFFFFC, 32'd3, 32'd3, 32'h8, 1'b0,
               1'b0, 32'h4, 32'h0, 1'b0};
    tv[9]  = '{3'b000, 32'h500, 32'd1, 32'd1, 32'h8, 1'b1,
               1'b0, 32'h508, 32'h504, 1'b1};
    tv[10] = '{3'b111, 32'h600, 32'd1, 32'd1, 32'h8, 1'b0,
               1'b0, 32'h608, 32'h604, 1'b0};
    tv[11] = '{3'b011, 32'h10, 32'd1, 32'hFFFFFFFF, 32'h4, 1'b1,
               1'b0, 32'h14, 32'h14, 1'b1};
    tv[12] = '{3'b101, 32'h10, 32'd1, 32'hFFFFFFFF, 32'h4, 1'b1,
               1'b1, 32'h14, 32'h14, 1'b0};
    tv[13] = '{3'b011, 32'h20, 32'h80000000, 32'h7FFFFFFF, 32'h100, 1'b0,
               1'b1, 32'h120, 32'h120, 1'b1};

    dirs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exps = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // reset state
    #2;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.taken", 64'(out_taken), 64'd0);
    chk("rst.target", 64'(out_target), 64'd0);
    chk("rst.redir", 64'(out_redirect_pc), 64'd0);
    chk("rst.mis", 64'(out_mispredict), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    lookup_pc = 32'h40;
    #1 chk("rst.lookup40", 64'(lookup_taken), 64'd0);
    lookup_pc = 32'h3C;
    #1 chk("rst.lookup3c", 64'(lookup_taken), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // BHT training and saturation at pc 0x40
    lookup_pc = 32'h40;
    for (int k = 0; k < 9; k++) begin
      drive(3'b001, 32'h40, 32'd9, dirs[k] ? 32'd9 : 32'd1, 32'h8, 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      #1;
      if (k == 0) chk("bht.preupdate", 64'(lookup_taken), 64'd0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk($sformatf("bht.step%0d", k), 64'(lookup_taken), 64'(exps[k]));
      if (k == 2) begin
        lookup_pc = 32'h80;
        #1 chk("bht.alias80", 64'(lookup_taken), 64'd1);
        lookup_pc = 32'h44;
        #1 chk("bht.other44", 64'(lookup_taken), 64'd0);
        lookup_pc = 32'h40;
      end
    end
    drive(3'b000, 32'h40, 32'd1, 32'd2, 32'h8, 1'b1);
    fire_one();
    drive(3'b111, 32'h40, 32'd1, 32'd2, 32'h8, 1'b0);
    fire_one();
    chk("bht.nonbranch", 64'(lookup_taken), 64'd1);
    chk("nonbr.taken", 64'(out_taken), 64'd0);

    // directed vector table
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(tv[i].typ, tv[i].pc, tv[i].rs1, tv[i].rs2, tv[i].imm,
            tv[i].pred);
      fire_one();
      chk($sformatf("v%0d.valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d.taken", i), 64'(out_taken), 64'(tv[i].taken));
      chk($sformatf("v%0d.target", i), 64'(out_target), 64'(tv[i].tgt));
      chk($sformatf("v%0d.redir", i), 64'(out_redirect_pc),
          64'(tv[i].redir));
      chk($sformatf("v%0d.mis", i), 64'(out_mispredict), 64'(tv[i].mis));
    end
    @(negedge clk);
    chk("drain.valid", 64'(out_valid), 64'd0);

    // backpressure hold and release
    drive(3'b001, 32'h1000, 32'd1, 32'd1, 32'h10, 1'b1);
    fire_one();
    chk("holdA.valid", 64'(out_valid), 64'd1);
    chk("holdA.target", 64'(out_target), 64'h1010);
    drive(3'b001, 32'h2000, 32'd1, 32'd1, 32'h20, 1'b1);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1 chk("hold.in_ready0", 64'(in_ready), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      chk($sformatf("hold%0d.in_ready", c), 64'(in_ready), 64'd0);
      chk($sformatf("hold%0d.valid", c), 64'(out_valid), 64'd1);
      chk($sformatf("hold%0d.target", c), 64'(out_target), 64'h1010);
      chk($sformatf("hold%0d.redir", c), 64'(out_redirect_pc), 64'h1010);
    end
    out_ready = 1'b1;
    #1 chk("rel.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("relB.valid", 64'(out_valid), 64'd1);
    chk("relB.target", 64'(out_target), 64'h2020);
    drive(3'b001, 32'h3000, 32'd1, 32'd1, 32'h30, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("relC.valid", 64'(out_valid), 64'd1);
    chk("relC.target", 64'(out_target), 64'h3030);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("relC.drain", 64'(out_valid), 64'd0);

    // async reset discards a held result and restores the BHT
    drive(3'b001, 32'h40, 32'd1, 32'd1, 32'h10, 1'b0);
    fire_one();
    fire_one();
    lookup_pc = 32'h40;
    out_ready = 1'b0;
    #1 chk("prerst.lookup", 64'(lookup_taken), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", 64'(out_valid), 64'd0);
    chk("midrst.target", 64'(out_target), 64'd0);
    chk("midrst.lookup", 64'(lookup_taken), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // flush during fire: no result, no training
    drive(3'b001, 32'h40, 32'd4, 32'd4, 32'h10, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    flush = 1'b1;
    #1 chk("flushfire.in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flushfire.valid", 64'(out_valid), 64'd0);
    chk("flushfire.bht", 64'(lookup_taken), 64'd0);
    fire_one();
    chk("postflush.bht", 64'(lookup_taken), 64'd1);

    // flush during hold
    out_ready = 1'b0;
    drive(3'b001, 32'h48, 32'd4, 32'd5, 32'h10, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    flush = 1'b1;
    lookup_pc = 32'h48;
    #1 chk("flushhold.in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flushhold.valid", 64'(out_valid), 64'd0);
    chk("flushhold.bht", 64'(lookup_taken), 64'd0);
    out_ready = 1'b1;

    // XLEN=64 variant
    issue64("w.blt", 3'b011, 64'h100, 64'hFFFFFFFF_FFFFFFFF, 64'd1,
            64'h40, 1'b1, 64'h140, 64'h140);
    issue64("w.bltu", 3'b101, 64'h100, 64'hFFFFFFFF_FFFFFFFF, 64'd1,
            64'h40, 1'b0, 64'h140, 64'h104);
    issue64("w.blt32", 3'b011, 64'h100, 64'h00000000_FFFFFFFF, 64'd1,
            64'h40, 1'b0, 64'h140, 64'h104);
    issue64("w.beqhi", 3'b001, 64'h100, 64'h00000001_00000000, 64'd0,
            64'h40, 1'b0, 64'h140, 64'h104);
    issue64("w.wrap", 3'b001, 64'hFFFFFFFF_FFFFFFFC, 64'd2, 64'd2,
            64'h8, 1'b1, 64'h4, 64'h4);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
